multu_sequencer: RTL and testbench

MULTU_SEQUENCER -- requirements
Module: multu_sequencer

---
 rtl/multu_sequencer.sv | 141 ++++++++++++++
 tb/tb_multu_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/multu_sequencer.sv
// -----------------------------------------------------------------------------
// multu_sequencer
//
// Sequential unsigned multiplier for the MULTU instruction. It uses one
// shift-add iteration per cycle. A start accepted in IDLE or DONE runs WIDTH
// iterations in RUN. The full 2*WIDTH-bit product then sits in {hi, lo}, and
// done pulses for one cycle. While a multiply is in flight, the sequencer stalls
// the front of the pipeline if EX holds an instruction that depends on it
// (another multu, mfhi or mflo).
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   asynchronous reset, active low
//   start     in   multu in EX this cycle
//   op_a      in   [WIDTH-1:0] multiplicand (rs)
//   op_b      in   [WIDTH-1:0] multiplier (rt)
//   rd_hi     in   mfhi in EX this cycle
//   rd_lo     in   mflo in EX this cycle
//   busy      out  multiply in progress (RUN)
//   stall     out  hold PC, IF/ID and ID/EX (drives enReg low)
//   done      out  one-cycle pulse when the product is final
//   hi        out  [WIDTH-1:0] upper product register
//   lo        out  [WIDTH-1:0] lower product register
//   mf_data   out  [WIDTH-1:0] hi when rd_hi, otherwise lo
//   mf_valid  out  mf_data is final and may be captured by EX/MEM
// -----------------------------------------------------------------------------
module multu_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             rd_hi,
  input  logic             rd_lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_data,
  output logic             mf_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH:0]   w_sum;
  logic             w_accept;
  logic             w_last;

  // A start is only taken when no multiply is in flight. A start seen during
  // RUN is held in EX by stall, and it is picked up again in DONE.
  assign w_accept = (r_state != S_RUN) && start;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // The partial-product add. Bit WIDTH is the carry out of hi. The carry is
  // shifted into hi[WIDTH-1] in the same cycle, so it never has to be stored
  // between iterations.
  assign w_sum = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_mcand}) : {1'b0, r_hi};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment before the case keeps this block purely
  // combinational; a path that leaves w_state_nxt unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: multiplicand, {hi, lo} shift register, iteration counter
  // ---------------------------------------------------------------------------
  // NOTE: every datapath register is reset, not only the control state. An
  // aborted multiply must leave hi/lo at zero, not at a half-built product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_mcand <= op_a;
      r_hi    <= '0;
      r_lo    <= op_b;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      // Shift {carry, hi, lo} right by one. The multiplier bits leave lo at the
      // bottom, and the product's low bits enter lo at the top.
      r_hi  <= w_sum[WIDTH:1];
      r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy    = (r_state == S_RUN);
    done    = (r_state == S_DONE);
    stall   = busy & (start | rd_hi | rd_lo);
    mf_data = rd_hi ? r_hi : r_lo;
    // mf_valid is gated by rst so that it reads 0 while reset is asserted,
    // even if an mfhi/mflo is sitting in EX.
    mf_valid = rst & (rd_hi | rd_lo) & ~busy;
    hi       = r_hi;
    lo       = r_lo;
  end

endmodule

// File: tb/tb_multu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multu_sequencer
//
// Directed testbench for multu_sequencer with WIDTH=32. Expected values are
// hand-computed constants. All comparisons are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_multu_sequencer;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             rd_hi;
  logic             rd_lo;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mf_data;
  logic             mf_valid;

  int n_checks = 0;
  int n_errors = 0;

  multu_sequencer #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .rd_hi    (rd_hi),
    .rd_lo    (rd_lo),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .mf_data  (mf_data),
    .mf_valid (mf_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue a one-cycle start from a falling edge. The task checks the busy
  // length and the done position (cycle index counted from the accepting
  // edge), then the product. The operands are scrambled mid-run, and that must
  // not change the result.
  task automatic mult(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] exp_hi, input logic [WIDTH-1:0] exp_lo);
    int busy_cnt;
    int done_at;
    busy_cnt = 0;
    done_at  = 0;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done && done_at == 0) done_at = k;
      if (k == 3) begin
        op_a = ~a;
        op_b = a ^ b ^ 32'h5A5A_A5A5;
      end
    end
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
    check({tag, "_done_cycle"}, 64'(done_at), 64'd33);
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    int bad;
    int found;
    rst   = 1'b0;
    start = 1'b1;
    op_a  = '0;
    op_b  = '0;
    rd_hi = 1'b0;
    rd_lo = 1'b1;

    // Reset state, with start and rd_lo asserted against the reset.
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_mf_valid", 64'(mf_valid), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    start = 1'b0;
    rd_lo = 1'b0;

    // Release reset on a falling edge; the first rising edge must accept.
    rst = 1'b1;
    mult("m3x5", 32'd3, 32'd5, 32'h0, 32'h0000_000F);
    mult("mffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    mult("m80x2", 32'h8000_0000, 32'd2, 32'h1, 32'h0);
    mult("mffx2", 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE);
    mult("m10kx10k", 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0);

    // hi/lo hold in IDLE; mf selection and priority.
    @(negedge clk);
    rd_hi = 1'b1;
    #1 check("mf_hi_data", 64'(mf_data), 64'h1);
    check("mf_hi_valid", 64'(mf_valid), 64'd1);
    rd_lo = 1'b1;
    #1 check("mf_prio_data", 64'(mf_data), 64'h1);
    rd_hi = 1'b0;
    #1 check("mf_lo_data", 64'(mf_data), 64'h0);
    rd_lo = 1'b0;
    #1 check("mf_none_valid", 64'(mf_valid), 64'd0);
    check("hold_hi", 64'(hi), 64'h1);

    mult("m0xb", 32'd0, 32'h0001_2345, 32'h0, 32'h0);
    mult("max0", 32'hDEAD_BEEF, 32'd0, 32'h0, 32'h0);

    // rd_lo held from cycle 5: stalled through RUN, valid in DONE.
    op_a  = 32'h1234;
    op_b  = 32'h10;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    bad = 0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k >= 5 && k <= 32 && (stall !== 1'b1 || mf_valid !== 1'b0)) bad++;
      if (k == 4) rd_lo = 1'b1;
      if (k == 33) begin
        check("rdlo_done", 64'(done), 64'd1);
        check("rdlo_stall_done", 64'(stall), 64'd0);
        check("rdlo_valid_done", 64'(mf_valid), 64'd1);
        check("rdlo_data_done", 64'(mf_data), 64'h0001_2340);
      end
    end
    rd_lo = 1'b0;
    check("rdlo_run_cycles_bad", 64'(bad), 64'd0);

    // Second start during RUN: stalled, first result intact, accepted in DONE.
    @(negedge clk);
    op_a  = 32'd3;
    op_b  = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k == 9) begin
        op_a  = 32'd7;
        op_b  = 32'd6;
        start = 1'b1;
      end
      if (k == 10) check("back_stall_run", 64'(stall), 64'd1);
      if (k == 33) begin
        check("back_done1", 64'(done), 64'd1);
        check("back_hi1", 64'(hi), 64'h0);
        check("back_lo1", 64'(lo), 64'h0000_000F);
      end
    end
    @(negedge clk);
    check("back_busy_again", 64'(busy), 64'd1);
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      @(negedge clk);
      if (done) found = 1;
    end
    check("back_done2_seen", 64'(found), 64'd1);
    check("back_lo2", 64'(lo), 64'd42);
    @(negedge clk);

    // Asynchronous reset at iteration 10: immediate clear, no done pulse.
    op_a  = 32'hFFFF_FFFF;
    op_b  = 32'hFFFF_FFFF;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1 check("arst_busy", 64'(busy), 64'd0);
    check("arst_hi", 64'(hi), 64'h0);
    check("arst_lo", 64'(lo), 64'h0);
    check("arst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) found = 1;
    end
    check("arst_no_done", 64'(found), 64'd0);
    mult("m7x6", 32'd7, 32'd6, 32'h0, 32'd42);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
